cook_sequencer: RTL and testbench

Sequences one microwave cook cycle. Accepts keypad digits as an MM:SS BCD cook time and handles start/stop/clear buttons and the door switch. Counts the time down on an internal 1 s tick, drives the magnetron enable, and signals completion. Sits between the keypad/button front end and the magnetron/display, replacing ad-hoc timer_done generation with a counted sequence.

---
 rtl/cook_pkg.sv | 25 ++
 rtl/bcd_time_reg.sv | 81 ++++++++
 rtl/cook_sequencer.sv | 164 ++++++++++++++++
 tb/tb_cook_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cook_pkg.sv
// Shared types and constants for the microwave cook sequencer.
package cook_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_SHIFT,
        OP_DEC,
        OP_ADD30,
        OP_QUICK
    } time_op_t;

    localparam logic [15:0] BCD_ZERO   = 16'h0000;
    localparam logic [15:0] QUICK_TIME = 16'h0030;
    localparam logic [15:0] BCD_MAX    = 16'h9959;

endpackage

// File: rtl/bcd_time_reg.sv
// MM:SS BCD cook-time register: clear, digit shift-in, one-second decrement,
// and (with QUICK_START_EN) quick-start load and saturating +30 s.
module bcd_time_reg
    import cook_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  time_op_t    op,
    input  logic [3:0]  digit,
    output logic [15:0] time_bcd,
    output logic        is_zero,
    output logic        is_one
);

    // Seconds digits above 5 are only reachable by entry; they count down
    // digit-wise like any other value (0:90 -> 0:89).
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = t;
        if (s0 != 4'd0) begin
            s0 = s0 - 4'd1;
        end else begin
            s0 = 4'd9;
            if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
            end else begin
                s1 = 4'd5;
                if (m0 != 4'd0) begin
                    m0 = m0 - 4'd1;
                end else begin
                    m0 = 4'd9;
                    m1 = m1 - 4'd1;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

`ifdef QUICK_START_EN
    function automatic logic [15:0] bcd_add30(input logic [15:0] t);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = t;
        if (s1 >= 4'd3) begin
            // s1 + 3 rolls past the sixty-second boundary into the minutes
            s1 = s1 - 4'd3;
            if (m1 == 4'd9 && m0 == 4'd9) begin
                return BCD_MAX;
            end else if (m0 == 4'd9) begin
                m0 = 4'd0;
                m1 = m1 + 4'd1;
            end else begin
                m0 = m0 + 4'd1;
            end
        end else begin
            s1 = s1 + 4'd3;
        end
        return {m1, m0, s1, s0};
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            time_bcd <= BCD_ZERO;
        end else begin
            unique case (op)
                OP_CLEAR: time_bcd <= BCD_ZERO;
                OP_SHIFT: time_bcd <= {time_bcd[11:0], digit};
                OP_DEC:   time_bcd <= bcd_dec(time_bcd);
`ifdef QUICK_START_EN
                OP_ADD30: time_bcd <= bcd_add30(time_bcd);
                OP_QUICK: time_bcd <= QUICK_TIME;
`endif
                default:  time_bcd <= time_bcd;
            endcase
        end
    end

    assign is_zero = (time_bcd == BCD_ZERO);
    assign is_one  = (time_bcd == 16'h0001);

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook-cycle sequencer: keypad time entry, start/stop/clear/door
// handling, 1 s countdown and done beep. Optional macro: QUICK_START_EN.
module cook_sequencer
    import cook_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned BEEP_SECS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        startn,
    input  logic        stopn,
    input  logic        clearn,
    input  logic        door_closed,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    output logic        mag,
    output logic        timer_done,
    output logic        done_beep,
    output logic [15:0] time_bcd,
    output logic [2:0]  state
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_SECS - 1);

    state_t          cur, nxt;
    time_op_t        op;
    logic [PW-1:0]   presc, presc_nxt;
    logic [BW-1:0]   beep_cnt;
    logic            start_q, stop_q, clear_q;
    logic            start_p, stop_p, clear_p;
    logic            tick, key_ok, is_zero, is_one;

    assign start_p = start_q & ~startn;
    assign stop_p  = stop_q & ~stopn;
    assign clear_p = clear_q & ~clearn;
    assign tick    = (presc == PRESC_LAST);
    assign key_ok  = key_valid & (key_digit <= 4'd9);

    bcd_time_reg u_time (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .digit    (key_digit),
        .time_bcd (time_bcd),
        .is_zero  (is_zero),
        .is_one   (is_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= IDLE;
            presc    <= '0;
            beep_cnt <= '0;
            start_q  <= 1'b1;
            stop_q   <= 1'b1;
            clear_q  <= 1'b1;
        end else begin
            cur      <= nxt;
            presc    <= presc_nxt;
            start_q  <= startn;
            stop_q   <= stopn;
            clear_q  <= clearn;
            if (cur != DONE)
                beep_cnt <= '0;
            else if (tick)
                beep_cnt <= beep_cnt + 1'b1;
        end
    end

    always_comb begin
        nxt        = cur;
        op         = OP_HOLD;
        timer_done = 1'b0;
        unique case (cur)
            IDLE: begin
`ifdef QUICK_START_EN
                if (start_p && door_closed) begin
                    op  = OP_QUICK;
                    nxt = COOK;
                end else
`endif
                if (key_ok) begin
                    op  = OP_SHIFT;
                    nxt = ENTRY;
                end
            end
            ENTRY: begin
                if (clear_p) begin
                    op  = OP_CLEAR;
                    nxt = IDLE;
                end else if (start_p && door_closed && !is_zero) begin
                    nxt = COOK;
`ifdef QUICK_START_EN
                end else if (start_p && door_closed) begin
                    op  = OP_QUICK;
                    nxt = COOK;
`endif
                end else if (key_ok) begin
                    op = OP_SHIFT;
                end
            end
            COOK: begin
                if (clear_p) begin
                    op  = OP_CLEAR;
                    nxt = IDLE;
                end else if (stop_p || !door_closed) begin
                    nxt = PAUSE;
`ifdef QUICK_START_EN
                // An add landing on a tick takes precedence; that tick is skipped.
                end else if (start_p) begin
                    op = OP_ADD30;
`endif
                end else if (tick) begin
                    op = OP_DEC;
                    if (is_one) begin
                        nxt        = DONE;
                        timer_done = 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (clear_p || stop_p) begin
                    op  = OP_CLEAR;
                    nxt = IDLE;
                end else if (start_p && door_closed) begin
                    nxt = COOK;
                end
            end
            DONE: begin
                if (start_p || stop_p || clear_p || !door_closed)
                    nxt = IDLE;
                else if (tick && beep_cnt == BEEP_LAST)
                    nxt = IDLE;
            end
            default: begin
                op  = OP_CLEAR;
                nxt = IDLE;
            end
        endcase
    end

    // The prescaler freezes on the way into PAUSE and on the way back out,
    // so a resumed cook finishes the partially elapsed second.
    always_comb begin
        presc_nxt = '0;
        if (nxt == IDLE || nxt == ENTRY)
            presc_nxt = '0;
        else if (nxt == PAUSE || cur == PAUSE)
            presc_nxt = presc;
        else if (cur == COOK || cur == DONE)
            presc_nxt = tick ? '0 : presc + 1'b1;
        else
            presc_nxt = '0;
    end

    assign mag       = (cur == COOK) & door_closed & ~rst;
    assign done_beep = (cur == DONE);
    assign state     = cur;

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed bench for cook_sequencer with TICK_DIV=4, BEEP_SECS=3.
module tb_cook_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_ENTRY = 3'd1, S_COOK = 3'd2,
                           S_PAUSE = 3'd3, S_DONE = 3'd4;
`ifdef QUICK_START_EN
    localparam bit QS = 1'b1;
`else
    localparam bit QS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, startn, stopn, clearn, door_closed, key_valid;
    logic [3:0]  key_digit;
    logic        mag, timer_done, done_beep;
    logic [15:0] time_bcd;
    logic [2:0]  state;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cook_sequencer #(.TICK_DIV(4), .BEEP_SECS(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .mag         (mag),
        .timer_done  (timer_done),
        .done_beep   (done_beep),
        .time_bcd    (time_bcd),
        .state       (state)
    );

    typedef struct {
        logic       rst, startn, stopn, clearn, door, kv;
        logic [3:0] kd;
        logic [2:0] st;
        logic [15:0] tm;
        logic       mag, td, beep;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic p, input logic c,
                                input logic door, input logic kv, input logic [3:0] kd,
                                input logic [2:0] st, input logic [15:0] tm,
                                input logic m, input logic td, input logic beep);
        vec_t v;
        v.rst = 1'b0; v.startn = s; v.stopn = p; v.clearn = c; v.door = door;
        v.kv = kv; v.kd = kd; v.st = st; v.tm = tm; v.mag = m; v.td = td; v.beep = beep;
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int secs);
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        startn = 1'b1; stopn = 1'b1; clearn = 1'b1; door_closed = 1'b1;
        key_valid = 1'b0; key_digit = 4'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1; key_digit = d;
        @(negedge clk);
        key_valid = 1'b0; key_digit = 4'd0;
    endtask

    task automatic press_start();
        startn = 1'b0;
        @(negedge clk);
        startn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Each row: inputs held for one cycle; expectations are the outputs
        // seen during that cycle, before the edge that consumes the inputs.
        //            startn stopn clearn door kv kd   state    time     mag td beep
        vecs.push_back(mk(1,1,1,1,0, 0, S_IDLE,  16'h0000,0,0,0)); // 0 reset state
        vecs.push_back(mk(1,1,1,1,1, 1, S_IDLE,  16'h0000,0,0,0)); // 1
        vecs.push_back(mk(1,1,1,1,1, 2, S_ENTRY, 16'h0001,0,0,0)); // 2
        vecs.push_back(mk(1,1,1,1,1,11, S_ENTRY, 16'h0012,0,0,0)); // 3 invalid key
        vecs.push_back(mk(1,1,1,1,0, 0, S_ENTRY, 16'h0012,0,0,0)); // 4
        vecs.push_back(mk(0,1,1,0,0, 0, S_ENTRY, 16'h0012,0,0,0)); // 5 start, door open
        vecs.push_back(mk(1,1,1,1,0, 0, S_ENTRY, 16'h0012,0,0,0)); // 6
        vecs.push_back(mk(0,1,1,1,0, 0, S_ENTRY, 16'h0012,0,0,0)); // 7 start
        vecs.push_back(mk(0,1,1,1,0, 0, S_COOK,  16'h0012,1,0,0)); // 8 held, presc 0
        vecs.push_back(mk(1,1,1,1,0, 0, S_COOK,  16'h0012,1,0,0)); // 9 presc 1
        vecs.push_back(mk(1,1,1,0,0, 0, S_COOK,  16'h0012,0,0,0)); // 10 door opens, presc 2
        vecs.push_back(mk(1,1,1,1,0, 0, S_PAUSE, 16'h0012,0,0,0)); // 11
        vecs.push_back(mk(1,1,1,1,0, 0, S_PAUSE, 16'h0012,0,0,0)); // 12
        vecs.push_back(mk(0,1,1,1,0, 0, S_PAUSE, 16'h0012,0,0,0)); // 13 resume
        vecs.push_back(mk(1,1,1,1,0, 0, S_COOK,  16'h0012,1,0,0)); // 14 presc 2
        vecs.push_back(mk(1,1,1,1,0, 0, S_COOK,  16'h0012,1,0,0)); // 15 presc 3, tick
        vecs.push_back(mk(1,1,1,1,0, 0, S_COOK,  16'h0011,1,0,0)); // 16
        vecs.push_back(mk(0,0,0,1,0, 0, S_COOK,  16'h0011,1,0,0)); // 17 all three buttons
        vecs.push_back(mk(1,1,1,1,0, 0, S_IDLE,  16'h0000,0,0,0)); // 18
        vecs.push_back(mk(1,1,1,1,1, 1, S_IDLE,  16'h0000,0,0,0)); // 19
        vecs.push_back(mk(1,1,1,1,1, 2, S_ENTRY, 16'h0001,0,0,0)); // 20
        vecs.push_back(mk(1,1,1,1,1, 3, S_ENTRY, 16'h0012,0,0,0)); // 21
        vecs.push_back(mk(1,1,1,1,1, 4, S_ENTRY, 16'h0123,0,0,0)); // 22
        vecs.push_back(mk(1,1,1,1,1, 5, S_ENTRY, 16'h1234,0,0,0)); // 23 fifth digit
        vecs.push_back(mk(1,1,1,1,1,15, S_ENTRY, 16'h2345,0,0,0)); // 24 invalid key
        vecs.push_back(mk(1,1,0,1,0, 0, S_ENTRY, 16'h2345,0,0,0)); // 25 clear
        vecs.push_back(mk(1,1,1,1,1, 0, S_IDLE,  16'h0000,0,0,0)); // 26 digit 0
        vecs.push_back(mk(0,1,1,1,0, 0, S_ENTRY, 16'h0000,0,0,0)); // 27 start, time 0000
        vecs.push_back(mk(1,1,1,1,0, 0, QS ? S_COOK : S_ENTRY, QS ? 16'h0030 : 16'h0000, QS,0,0)); // 28
        vecs.push_back(mk(1,1,0,1,0, 0, QS ? S_COOK : S_ENTRY, QS ? 16'h0030 : 16'h0000, QS,0,0)); // 29
        vecs.push_back(mk(0,1,1,1,0, 0, S_IDLE,  16'h0000,0,0,0)); // 30 start in IDLE
        vecs.push_back(mk(1,1,1,1,0, 0, QS ? S_COOK : S_IDLE, QS ? 16'h0030 : 16'h0000, QS,0,0)); // 31
        vecs.push_back(mk(1,1,0,1,0, 0, QS ? S_COOK : S_IDLE, QS ? 16'h0030 : 16'h0000, QS,0,0)); // 32
        vecs.push_back(mk(1,1,1,1,0, 0, S_IDLE,  16'h0000,0,0,0)); // 33

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; startn = vecs[i].startn; stopn = vecs[i].stopn;
            clearn = vecs[i].clearn; door_closed = vecs[i].door;
            key_valid = vecs[i].kv; key_digit = vecs[i].kd;
            #1;
            chk($sformatf("v%0d state", i), 16'(state), 16'(vecs[i].st));
            chk($sformatf("v%0d time", i), time_bcd, vecs[i].tm);
            chk($sformatf("v%0d mag", i), 16'(mag), 16'(vecs[i].mag));
            chk($sformatf("v%0d timer_done", i), 16'(timer_done), 16'(vecs[i].td));
            chk($sformatf("v%0d done_beep", i), 16'(done_beep), 16'(vecs[i].beep));
            @(negedge clk);
        end

        // Normal cook of 12 s: 48 COOK cycles, then 12 DONE cycles, then IDLE.
        do_reset();
        key(4'd1);
        key(4'd2);
        press_start();
        for (int i = 0; i < 48; i++) begin
            #1;
            chk($sformatf("cook%0d state", i), 16'(state), 16'(S_COOK));
            chk($sformatf("cook%0d mag", i), 16'(mag), 16'd1);
            chk($sformatf("cook%0d time", i), time_bcd, to_bcd(12 - i / 4));
            chk($sformatf("cook%0d timer_done", i), 16'(timer_done), 16'(i == 47));
            @(negedge clk);
        end
        for (int j = 0; j < 12; j++) begin
            #1;
            chk($sformatf("done%0d state", j), 16'(state), 16'(S_DONE));
            chk($sformatf("done%0d beep", j), 16'(done_beep), 16'd1);
            chk($sformatf("done%0d mag", j), 16'(mag), 16'd0);
            chk($sformatf("done%0d time", j), time_bcd, 16'h0000);
            chk($sformatf("done%0d timer_done", j), 16'(timer_done), 16'd0);
            @(negedge clk);
        end
        #1;
        chk("after_done state", 16'(state), 16'(S_IDLE));
        chk("after_done beep", 16'(done_beep), 16'd0);
        @(negedge clk);

        // Minute borrow 1:00 -> 0:59 -> 0:58, then reset mid-cook.
        do_reset();
        key(4'd1);
        key(4'd0);
        key(4'd0);
        press_start();
        for (int i = 0; i < 9; i++) begin
            #1;
            chk($sformatf("borrow%0d time", i), time_bcd,
                (i < 4) ? 16'h0100 : ((i < 8) ? 16'h0059 : 16'h0058));
            chk($sformatf("borrow%0d mag", i), 16'(mag), 16'd1);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst state", 16'(state), 16'(S_IDLE));
        chk("rst mag", 16'(mag), 16'd0);
        chk("rst time", time_bcd, 16'h0000);
        chk("rst beep", 16'(done_beep), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
